seg_scan_decoder: RTL

Receive-side decoder for the multiplexed 4-digit seven-segment bus (`an`, `seg_code`) driven by the quiz responder's display logic. It samples the scanned digit enables and segment lines, debounces each digit dwell, and maps each segment pattern back to a hex value. It then assembles complete 4-digit frames with per-digit blank and decimal-point flags. It sits in the bench and monitor path and on boards where a second FPGA reads the display bus, giving a checkable numeric view of what the responder shows.

---
 rtl/seg_scan_decoder_if.sv | 8 +
 rtl/seg_scan_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder_if.sv
// Scanned seven-segment display bus: active-low digit enables and active-low segment lines.
interface seg_scan_decoder_if;
    logic [3:0] an;
    logic [7:0] seg_code;

    modport master (output an, output seg_code);
    modport slave  (input  an, input  seg_code);
endinterface

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 4-digit seven-segment bus back into hex frames with blank/dp flags.
// Optional saturating error counter is built when SEG_SCAN_ERRCNT_EN is defined.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    seg_scan_decoder_if.slave        bus,
    output logic [15:0]              frame_hex,
    output logic [3:0]               frame_blank,
    output logic [3:0]               frame_dp,
    output logic                     frame_valid,
    output logic                     stale,
    output logic                     err,
    output logic [7:0]               err_cnt
);
    localparam logic [7:0]  STABLE_W  = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    logic [11:0] smp_q, prv_q;
    logic [7:0]  dwell_q, dwell_d;
    logic        captured_q, captured_d;
    logic [15:0] to_q, to_d;
    logic [3:0]  seen_q, seen_d, seen_next;
    logic [15:0] work_hex_q, work_hex_d;
    logic [3:0]  work_blank_q, work_blank_d, work_dp_q, work_dp_d;
    logic [15:0] frame_hex_q, frame_hex_d;
    logic [3:0]  frame_blank_q, frame_blank_d, frame_dp_q, frame_dp_d;
    logic        valid_q, valid_d, err_q, err_d, stale_q, stale_d;

    logic        changed, evaluate, one_digit, multi, pat_ok, capture, frame_done, timeout_hit;
    logic [1:0]  dig_sel;
    logic [6:0]  pat;
    logic [3:0]  pat_hex;

    // Returns {recognised, hex}; an all-off pattern is recognised as blank with hex 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h00: seg_decode = 5'h10;
            7'h3F: seg_decode = 5'h10;
            7'h06: seg_decode = 5'h11;
            7'h5B: seg_decode = 5'h12;
            7'h4F: seg_decode = 5'h13;
            7'h66: seg_decode = 5'h14;
            7'h6D: seg_decode = 5'h15;
            7'h7D: seg_decode = 5'h16;
            7'h07: seg_decode = 5'h17;
            7'h7F: seg_decode = 5'h18;
            7'h6F: seg_decode = 5'h19;
            7'h77: seg_decode = 5'h1A;
            7'h7C: seg_decode = 5'h1B;
            7'h39: seg_decode = 5'h1C;
            7'h5E: seg_decode = 5'h1D;
            7'h79: seg_decode = 5'h1E;
            7'h71: seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        // Dwell is measured on the registered sample versus the one before it,
        // so a capture lands STABLE_CYCLES edges after the pattern first hits the pins.
        changed = (smp_q != prv_q);
        if (changed)                 dwell_d = 8'd1;
        else if (dwell_q >= STABLE_W) dwell_d = STABLE_W;
        else                          dwell_d = dwell_q + 8'd1;
        evaluate   = !changed && (dwell_d == STABLE_W) && !captured_q;
        captured_d = changed ? 1'b0 : (captured_q | evaluate);

        one_digit = 1'b0;
        multi     = 1'b0;
        dig_sel   = 2'd0;
        case (smp_q[11:8])
            4'hE:    begin one_digit = 1'b1; dig_sel = 2'd0; end
            4'hD:    begin one_digit = 1'b1; dig_sel = 2'd1; end
            4'hB:    begin one_digit = 1'b1; dig_sel = 2'd2; end
            4'h7:    begin one_digit = 1'b1; dig_sel = 2'd3; end
            4'hF:    ;
            default: multi = 1'b1;
        endcase

        pat               = ~smp_q[6:0];
        {pat_ok, pat_hex} = seg_decode(pat);
        capture           = evaluate && one_digit && pat_ok;
        err_d             = evaluate && (multi || (one_digit && !pat_ok));

        work_hex_d   = work_hex_q;
        work_blank_d = work_blank_q;
        work_dp_d    = work_dp_q;
        seen_next    = seen_q;
        if (capture) begin
            work_hex_d[{dig_sel, 2'b00} +: 4] = pat_hex;
            work_blank_d[dig_sel]             = (pat == 7'h00);
            work_dp_d[dig_sel]                = ~smp_q[7];
            seen_next[dig_sel]                = 1'b1;
        end
        frame_done = capture && (seen_next == 4'hF);

        if (capture)                to_d = '0;
        else if (to_q >= TIMEOUT_W) to_d = TIMEOUT_W;
        else                        to_d = to_q + 16'd1;
        timeout_hit = (to_d == TIMEOUT_W);

        seen_d        = (frame_done || timeout_hit) ? 4'h0 : seen_next;
        frame_hex_d   = frame_done ? work_hex_d   : frame_hex_q;
        frame_blank_d = frame_done ? work_blank_d : frame_blank_q;
        frame_dp_d    = frame_done ? work_dp_d    : frame_dp_q;
        valid_d       = frame_done;
        stale_d       = frame_done ? 1'b0 : (timeout_hit ? 1'b1 : stale_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q         <= '0;
            prv_q         <= '0;
            dwell_q       <= '0;
            captured_q    <= 1'b0;
            to_q          <= '0;
            seen_q        <= '0;
            work_hex_q    <= '0;
            work_blank_q  <= '0;
            work_dp_q     <= '0;
            frame_hex_q   <= '0;
            frame_blank_q <= '0;
            frame_dp_q    <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            stale_q       <= 1'b1;
        end else begin
            smp_q         <= {bus.an, bus.seg_code};
            prv_q         <= smp_q;
            dwell_q       <= dwell_d;
            captured_q    <= captured_d;
            to_q          <= to_d;
            seen_q        <= seen_d;
            work_hex_q    <= work_hex_d;
            work_blank_q  <= work_blank_d;
            work_dp_q     <= work_dp_d;
            frame_hex_q   <= frame_hex_d;
            frame_blank_q <= frame_blank_d;
            frame_dp_q    <= frame_dp_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            stale_q       <= stale_d;
        end
    end

`ifdef SEG_SCAN_ERRCNT_EN
    logic [7:0] errcnt_q;
    always_ff @(posedge clk) begin
        if (rst)                              errcnt_q <= '0;
        else if (err_d && errcnt_q != 8'hFF)  errcnt_q <= errcnt_q + 8'd1;
    end
    assign err_cnt = errcnt_q;
`else
    assign err_cnt = '0;
`endif

    assign frame_hex   = frame_hex_q;
    assign frame_blank = frame_blank_q;
    assign frame_dp    = frame_dp_q;
    assign frame_valid = valid_q;
    assign stale       = stale_q;
    assign err         = err_q;
endmodule
